trig_out_prescaler: RTL and testbench

//  Downstream stage of the PID trigger logic. Takes the six particle-ID trigger bits
//  (Electron/Muon/Pion, up/down) and applies per-channel edge detection and prescaling.

---
 rtl/trig_pkg.sv | 28 ++
 rtl/trig_prescale_ch.sv | 69 ++++++
 rtl/trig_out_prescaler.sv | 177 +++++++++++++++++
 tb/tb_trig_out_prescaler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// trig_pkg : shared constants and FSM encoding for trig_out_prescaler
// Rev 1.0
// ------------------------------------------------------------------
package trig_pkg;

  localparam int N_CH = 6;

  localparam logic [7:0] c_OFF_CTRL   = 8'h00;
  localparam logic [7:0] c_OFF_PS     = 8'h01;
  localparam logic [7:0] c_OFF_RAW    = 8'h10;
  localparam logic [7:0] c_OFF_ACC    = 8'h20;
  localparam logic [7:0] c_OFF_STATUS = 8'h30;

  localparam logic [15:0] c_PS_DEFAULT      = 16'd1;
  localparam logic [7:0]  c_WIDTH_DEFAULT   = 8'd4;
  localparam logic [15:0] c_HOLDOFF_DEFAULT = 16'd0;
  localparam logic        c_EN_DEFAULT      = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/trig_prescale_ch.sv
`default_nettype none
// ------------------------------------------------------------------
// trig_prescale_ch : one channel - sync, edge detect, prescale, scalers
// Rev 1.0
// ------------------------------------------------------------------
module trig_prescale_ch #(
  parameter int PS_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             i_trig,
  input  logic [PS_W-1:0]  i_ps,
  input  logic             i_ps_wr,
  input  logic             i_clr,
  input  logic             i_fire,
  output logic             o_acc,
  output logic [CNT_W-1:0] o_raw,
  output logic [CNT_W-1:0] o_accs
);

  logic             r_meta, r_sync, r_sync_d;
  logic             r_acc;
  logic [PS_W-1:0]  r_cnt;
  logic [CNT_W-1:0] r_raw, r_accs;
  logic             w_hit, w_en;

  assign w_hit = r_sync & ~r_sync_d;
  assign w_en  = (i_ps != '0);

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_acc    <= 1'b0;
      r_cnt    <= '0;
      r_raw    <= '0;
      r_accs   <= '0;
    end else begin
      r_meta   <= i_trig;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_acc    <= w_hit && w_en && (r_cnt == '0);

      if (i_ps_wr)
        r_cnt <= '0;
      else if (w_hit && w_en)
        r_cnt <= (r_cnt == i_ps - PS_W'(1)) ? '0 : r_cnt + PS_W'(1);

      // clear takes priority over a coincident increment
      if (i_clr)
        r_raw <= '0;
      else if (w_hit && (r_raw != '1))
        r_raw <= r_raw + CNT_W'(1);

      if (i_clr)
        r_accs <= '0;
      else if (i_fire && r_acc && (r_accs != '1))
        r_accs <= r_accs + CNT_W'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_raw  = r_raw;
  assign o_accs = r_accs;

endmodule
`default_nettype wire

// File: rtl/trig_out_prescaler.sv
`default_nettype none
// ------------------------------------------------------------------
// trig_out_prescaler : PID trigger prescale, busy veto, TRIG_OUT pulse
// Rev 1.0
// ------------------------------------------------------------------
module trig_out_prescaler #(
  parameter int          N_CH      = trig_pkg::N_CH,
  parameter int          PS_W      = 16,
  parameter int          CNT_W     = 32,
  parameter logic [15:0] BASE_ADDR = 16'hA000
) (
  input  logic            clk_100_i,
  input  logic            reset_i,
  input  logic [N_CH-1:0] trig_in,
  input  logic            busy_i,
  output logic [N_CH:0]   trig_out,
  input  logic [15:0]     addr,
  input  logic [31:0]     data,
  input  logic            wr,
  input  logic            rd,
  output logic [31:0]     rdata,
  output logic            ack
);
  import trig_pkg::*;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic [N_CH:0]    r_trig, w_trig_nxt;
  logic             r_en;
  logic [7:0]       r_width;
  logic [15:0]      r_holdoff;
  logic [PS_W-1:0]  r_ps [N_CH];
  logic [N_CH-1:0]  r_last, w_acc, w_ps_wr;
  logic [15:0]      r_veto;
  logic [CNT_W-1:0] w_raw [N_CH];
  logic [CNT_W-1:0] w_accs [N_CH];
  logic             w_fire, w_clr, w_dec, w_dec_ctrl;
  logic [15:0]      w_off;
  logic [31:0]      w_rval, r_rdata;
  logic             r_ack;
  logic             w_unused;

  assign w_off    = addr - BASE_ADDR;
  assign w_unused = &{1'b0, data[7:2]};

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    trig_prescale_ch #(.PS_W(PS_W), .CNT_W(CNT_W)) u_ch (
      .clk     (clk_100_i),
      .reset_i (reset_i),
      .i_trig  (trig_in[gi]),
      .i_ps    (r_ps[gi]),
      .i_ps_wr (w_ps_wr[gi]),
      .i_clr   (w_clr),
      .i_fire  (w_fire),
      .o_acc   (w_acc[gi]),
      .o_raw   (w_raw[gi]),
      .o_accs  (w_accs[gi])
    );
  end

  always_comb begin
    w_dec      = 1'b0;
    w_dec_ctrl = 1'b0;
    w_ps_wr    = '0;
    w_rval     = '0;
    if (w_off[15:8] == 8'h00) begin
      if (w_off[7:0] == c_OFF_CTRL) begin
        w_dec      = 1'b1;
        w_dec_ctrl = 1'b1;
        w_rval     = {r_holdoff, r_width, 7'b0, r_en};
      end
      if (w_off[7:0] == c_OFF_STATUS) begin
        w_dec            = 1'b1;
        w_rval[31:16]    = r_veto;
        w_rval[8 +: N_CH] = r_last;
        w_rval[1:0]      = r_state;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (w_off[7:0] == c_OFF_PS + 8'(i)) begin
          w_dec      = 1'b1;
          w_ps_wr[i] = wr;
          w_rval     = 32'(r_ps[i]);
        end
        if (w_off[7:0] == c_OFF_RAW + 8'(i)) begin
          w_dec  = 1'b1;
          w_rval = 32'(w_raw[i]);
        end
        if (w_off[7:0] == c_OFF_ACC + 8'(i)) begin
          w_dec  = 1'b1;
          w_rval = 32'(w_accs[i]);
        end
      end
    end
  end

  assign w_clr  = wr && w_dec_ctrl && data[1];
  assign w_fire = (r_state == S_IDLE) && r_en && !busy_i && (|w_acc);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trig_nxt  = r_trig;
    case (r_state)
      S_IDLE: begin
        if (w_fire) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = (r_width == 8'd0) ? 16'd1 : 16'(r_width);
          w_trig_nxt  = {1'b1, w_acc};
        end
      end
      S_PULSE: begin
        if (r_cnt <= 16'd1) begin
          w_trig_nxt  = '0;
          w_cnt_nxt   = r_holdoff;
          w_state_nxt = (r_holdoff == 16'd0) ? S_IDLE : S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt <= 16'd1) w_state_nxt = S_IDLE;
        else                w_cnt_nxt   = r_cnt - 16'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_trig_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_trig  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trig  <= w_trig_nxt;
    end
  end

  always_ff @(posedge clk_100_i) begin
    if (!reset_i) begin
      r_en      <= c_EN_DEFAULT;
      r_width   <= c_WIDTH_DEFAULT;
      r_holdoff <= c_HOLDOFF_DEFAULT;
      for (int i = 0; i < N_CH; i++) r_ps[i] <= PS_W'(c_PS_DEFAULT);
      r_last    <= '0;
      r_veto    <= '0;
      r_ack     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_fire) r_last <= w_acc;
      // one veto per cycle in which any channel's accept is dropped
      if (w_clr)
        r_veto <= '0;
      else if ((|w_acc) && !w_fire && (r_veto != 16'hFFFF))
        r_veto <= r_veto + 16'd1;
      r_ack   <= (wr || rd) && w_dec;
      r_rdata <= (rd && w_dec) ? w_rval : '0;
      if (wr && w_dec_ctrl) begin
        r_en      <= data[0];
        r_width   <= data[15:8];
        r_holdoff <= data[31:16];
      end
      for (int i = 0; i < N_CH; i++)
        if (w_ps_wr[i]) r_ps[i] <= data[PS_W-1:0];
    end
  end

  assign trig_out = r_trig;
  assign rdata    = r_rdata;
  assign ack      = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_trig_out_prescaler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_trig_out_prescaler : directed self-checking bench
// Rev 1.0
// ------------------------------------------------------------------
module tb_trig_out_prescaler;

  logic        clk_100_i = 1'b0;
  logic        reset_i;
  logic [5:0]  trig_in;
  logic        busy_i;
  logic [6:0]  trig_out, s_trig_out;
  logic [15:0] addr;
  logic [31:0] data;
  logic        wr, rd;
  logic [31:0] rdata, s_rdata;
  logic        ack, s_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_100_i = ~clk_100_i;

  trig_out_prescaler u_dut (
    .clk_100_i (clk_100_i), .reset_i (reset_i), .trig_in (trig_in), .busy_i (busy_i),
    .trig_out  (trig_out),  .addr    (addr),    .data    (data),    .wr     (wr),
    .rd        (rd),        .rdata   (rdata),   .ack     (ack)
  );

  // narrow-scaler instance so saturation is reachable in a short run
  trig_out_prescaler #(.CNT_W(4)) u_sat (
    .clk_100_i (clk_100_i), .reset_i (reset_i), .trig_in (trig_in), .busy_i (busy_i),
    .trig_out  (s_trig_out), .addr   (addr),    .data    (data),    .wr     (wr),
    .rd        (rd),        .rdata   (s_rdata), .ack     (s_ack)
  );

  task automatic tick();
    @(posedge clk_100_i);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr = a; data = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d,
                          output logic [31:0] sd, output logic ok);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    ok = ack; d = rdata; sd = s_rdata;
    tick();
  endtask

  task automatic run_ch(input int ch, input int hits, input int spacing,
                        output int ntrig, output int nhi, output logic [6:0] pat);
    logic [6:0] prev;
    prev = '0; ntrig = 0; nhi = 0; pat = '0;
    for (int h = 0; h < hits; h++) begin
      for (int c = 0; c < spacing; c++) begin
        trig_in[ch] = (c < 2);
        tick();
        if (trig_out != '0) begin
          nhi++;
          pat |= trig_out;
          if (prev == '0) ntrig++;
        end
        prev = trig_out;
      end
    end
    trig_in[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, sd;
    logic        ok;
    reset_i = 1'b0; trig_in = '0; busy_i = 1'b0;
    addr = '0; data = '0; wr = 1'b0; rd = 1'b0;
    repeat (3) tick();
    n_tests++; if (trig_out !== 7'h00) begin n_fail++; $display("FAIL reset_trig_out: got %h expected %h", trig_out, 7'h00); end
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset_i = 1'b1;
    tick();
    bus_read(16'hA000, d, sd, ok);
    n_tests++; if (ok !== 1'b1 || d !== 32'h0000_0401) begin n_fail++; $display("FAIL reset_ctrl: got ack=%b data=%h expected ack=1 data=00000401", ok, d); end
    bus_read(16'hA001, d, sd, ok);
    n_tests++; if (ok !== 1'b1 || d !== 32'h1) begin n_fail++; $display("FAIL reset_ps0: got ack=%b data=%h expected ack=1 data=1", ok, d); end
    bus_read(16'hA040, d, sd, ok);
    n_tests++; if (ok !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL undecoded_40: got ack=%b data=%h expected ack=0 data=0", ok, d); end
    bus_read(16'hA016, d, sd, ok);
    n_tests++; if (ok !== 1'b0) begin n_fail++; $display("FAIL undecoded_16: got ack=%b expected 0", ok); end
  endtask

  task automatic test_prescale();
    int ntrig, nhi;
    logic [6:0]  pat;
    logic [31:0] d, sd;
    logic        ok;
    bus_write(16'hA001, 32'd3);
    run_ch(0, 7, 20, ntrig, nhi, pat);
    n_tests++; if (ntrig !== 3) begin n_fail++; $display("FAIL ps3_triggers: got %0d expected 3", ntrig); end
    n_tests++; if (nhi !== 12) begin n_fail++; $display("FAIL ps3_high_cycles: got %0d expected 12", nhi); end
    n_tests++; if (pat !== 7'h41) begin n_fail++; $display("FAIL ps3_pattern: got %h expected 41", pat); end
    bus_read(16'hA010, d, sd, ok);
    n_tests++; if (d !== 32'd7) begin n_fail++; $display("FAIL raw0: got %0d expected 7", d); end
    bus_read(16'hA020, d, sd, ok);
    n_tests++; if (d !== 32'd3) begin n_fail++; $display("FAIL acc0: got %0d expected 3", d); end
  endtask

  task automatic test_simultaneous();
    int nhi;
    trig_in = 6'b010010;
    tick(); tick(); tick();
    n_tests++; if (trig_out !== 7'h00) begin n_fail++; $display("FAIL latency_early: got %h expected 00", trig_out); end
    tick();
    n_tests++; if (trig_out !== 7'h52) begin n_fail++; $display("FAIL latency_pattern: got %h expected 52", trig_out); end
    trig_in = '0;
    nhi = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (trig_out != '0) nhi++;
    end
    n_tests++; if (nhi !== 4) begin n_fail++; $display("FAIL simul_width: got %0d expected 4", nhi); end
  endtask

  task automatic test_holdoff();
    int ntrig, nhi;
    logic [6:0]  prev;
    logic [31:0] d, sd;
    logic        ok;
    bus_write(16'hA000, 32'h000A_0203);
    ntrig = 0; nhi = 0; prev = '0;
    for (int c = 0; c < 40; c++) begin
      trig_in[2] = (c == 0 || c == 1 || c == 5 || c == 6 || c == 15 || c == 16);
      tick();
      if (trig_out != '0) begin
        nhi++;
        if (prev == '0) ntrig++;
      end
      prev = trig_out;
    end
    trig_in[2] = 1'b0;
    n_tests++; if (ntrig !== 2) begin n_fail++; $display("FAIL holdoff_triggers: got %0d expected 2", ntrig); end
    n_tests++; if (nhi !== 4) begin n_fail++; $display("FAIL holdoff_high_cycles: got %0d expected 4", nhi); end
    bus_read(16'hA030, d, sd, ok);
    n_tests++; if (d !== 32'h0001_0400) begin n_fail++; $display("FAIL holdoff_status: got %h expected 00010400", d); end
    bus_write(16'hA000, 32'h0000_0401);
  endtask

  task automatic test_busy();
    int ntrig, nhi;
    logic [6:0]  pat;
    logic [31:0] d, sd;
    logic        ok;
    busy_i = 1'b1;
    run_ch(3, 1, 12, ntrig, nhi, pat);
    busy_i = 1'b0;
    n_tests++; if (ntrig !== 0) begin n_fail++; $display("FAIL busy_triggers: got %0d expected 0", ntrig); end
    bus_read(16'hA013, d, sd, ok);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL busy_raw3: got %0d expected 1", d); end
    bus_read(16'hA023, d, sd, ok);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL busy_acc3: got %0d expected 0", d); end
    run_ch(5, 17, 6, ntrig, nhi, pat);
    bus_read(16'hA015, d, sd, ok);
    n_tests++; if (d !== 32'd17) begin n_fail++; $display("FAIL raw5_count: got %0d expected 17", d); end
    n_tests++; if (sd !== 32'h0000_000F) begin n_fail++; $display("FAIL raw5_saturate: got %h expected 0000000f", sd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, sd;
    logic        ok;
    addr = 16'hA002; data = 32'd5; wr = 1'b1; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    n_tests++; if (ack !== 1'b1 || rdata !== 32'd1) begin n_fail++; $display("FAIL wr_rd_same: got ack=%b data=%h expected ack=1 data=1", ack, rdata); end
    tick();
    n_tests++; if (ack !== 1'b0 || rdata !== 32'd0) begin n_fail++; $display("FAIL ack_release: got ack=%b data=%h expected ack=0 data=0", ack, rdata); end
    bus_read(16'hA002, d, sd, ok);
    n_tests++; if (d !== 32'd5) begin n_fail++; $display("FAIL ps2_written: got %0d expected 5", d); end
    bus_write(16'hA002, 32'd1);
  endtask

  task automatic test_reset_pulse();
    logic [31:0] d, sd;
    logic        ok;
    int          w;
    trig_in[1] = 1'b1;
    w = 0;
    while (trig_out == '0 && w < 10) begin
      tick();
      w++;
    end
    n_tests++; if (trig_out !== 7'h42) begin n_fail++; $display("FAIL pulse_wait: got %h expected 42", trig_out); end
    trig_in[1] = 1'b0;
    tick();
    reset_i = 1'b0;
    tick();
    n_tests++; if (trig_out !== 7'h00) begin n_fail++; $display("FAIL reset_mid_pulse: got %h expected 00", trig_out); end
    reset_i = 1'b1;
    tick();
    bus_read(16'hA001, d, sd, ok);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL ps0_after_reset: got %0d expected 1", d); end
    busy_i = 1'b1;
    trig_in[0] = 1'b1;
    tick(); tick();
    addr = 16'hA000; data = 32'h0000_0403; wr = 1'b1;
    tick();
    wr = 1'b0; trig_in[0] = 1'b0;
    tick();
    busy_i = 1'b0;
    repeat (5) tick();
    bus_read(16'hA010, d, sd, ok);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL clr_raw0: got %0d expected 0", d); end
    bus_read(16'hA020, d, sd, ok);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL clr_acc0: got %0d expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_simultaneous();
    test_holdoff();
    test_busy();
    test_back_to_back();
    test_reset_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
